// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU memory path: bus widths, memory map
// boundaries and the access-unit FSM state encoding.
package cpu8_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [ADDR_W-1:0] ROM_TOP = 8'h7F;
  localparam logic [ADDR_W-1:0] IO_BASE = 8'hE0;

  typedef enum logic [2:0] {
    ARB    = 3'd0,
    F_CAP  = 3'd1,
    HOLD   = 3'd2,
    LS     = 3'd3,
    LS_CAP = 3'd4
  } mau_state_e;

  // True when the address lies in the read-only program region.
  function automatic logic in_rom(input logic [ADDR_W-1:0] addr,
                                  input logic [ADDR_W-1:0] top);
    return addr <= top;
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Arbitrates one single-ported memory between instruction fetch and a
// load/store requester; loads/stores win arbitration, stores to ROM fault.
module mem_access_unit
  import cpu8_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [ADDR_W-1:0] ROM_TOP  = cpu8_pkg::ROM_TOP
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_fault,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target
);

  mau_state_e        r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_ls_we;
  logic [ADDR_W-1:0] r_ls_addr;
  logic [DATA_W-1:0] r_ls_wdata;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              r_ls_ack;
  logic [DATA_W-1:0] r_ls_rdata;
  logic              r_ls_fault;

  logic              w_ls_take;
  logic              w_ls_write_ok;

  // A request is not accepted in its own ack cycle, so a requester still
  // holding ls_req there is not serviced twice.
  assign w_ls_take     = ls_req && !r_ls_ack;
  assign w_ls_write_ok = r_ls_we && !in_rom(r_ls_addr, ROM_TOP);

  // Memory-side outputs depend only on registered state.
  always_comb begin
    mem_address = (r_state == LS) ? r_ls_addr : r_pc;
    mem_data_in = r_ls_wdata;
    mem_write   = (r_state == LS) && w_ls_write_ok;
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign ls_ack      = r_ls_ack;
  assign ls_rdata    = r_ls_rdata;
  assign ls_fault    = r_ls_fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ARB;
      r_pc          <= RESET_PC;
      r_ls_we       <= 1'b0;
      r_ls_addr     <= '0;
      r_ls_wdata    <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
      r_ls_ack      <= 1'b0;
      r_ls_rdata    <= '0;
      r_ls_fault    <= 1'b0;
    end else begin
      r_ls_ack   <= 1'b0;
      r_ls_fault <= 1'b0;
      case (r_state)
        ARB: begin
          if (w_ls_take) begin
            r_ls_we    <= ls_we;
            r_ls_addr  <= ls_addr;
            r_ls_wdata <= ls_wdata;
            r_state    <= LS;
          end else if (jump) begin
            // The address already presented is stale; re-arbitrate at the target.
            r_state <= ARB;
          end else begin
            r_state <= F_CAP;
          end
        end
        F_CAP: begin
          if (jump) begin
            r_state <= ARB;
          end else begin
            r_instr       <= mem_data_out;
            r_instr_pc    <= r_pc;
            r_instr_valid <= 1'b1;
            r_pc          <= r_pc + 8'd1;
            r_state       <= HOLD;
          end
        end
        HOLD: begin
          if (jump || instr_ready) begin
            r_instr_valid <= 1'b0;
            r_state       <= ARB;
          end
        end
        LS: begin
          if (r_ls_we) begin
            r_ls_ack   <= 1'b1;
            r_ls_fault <= !w_ls_write_ok;
            r_state    <= ARB;
          end else begin
            r_state <= LS_CAP;
          end
        end
        LS_CAP: begin
          r_ls_rdata <= mem_data_out;
          r_ls_ack   <= 1'b1;
          r_state    <= ARB;
        end
        default: r_state <= ARB;
      endcase
      if (jump) begin
        r_pc <= jump_target;
      end
    end
  end

endmodule
